// File: rtl/cla_pkg.sv
// Shared types and helpers for the arbitrated carry-look-ahead adder.
package cla_pkg;

    localparam int ADD_W    = 32;
    localparam int ID_MAX_W = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
        logic             cin;
    } add_op_t;

    typedef struct packed {
        logic [ADD_W-1:0]    sum;
        logic                cout;
        logic [ID_MAX_W-1:0] id;
    } add_rsp_t;

endpackage

// File: rtl/cla32btadder.sv
// 32-bit two-level carry-look-ahead adder: 4-bit lookahead groups,
// group generate/propagate chained across the eight groups.
module cla32btadder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [8:0]  w_gc;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        logic [3:0] g;
        logic [3:0] p;
        logic       c0;
        logic       grp_g;
        g     = '0;
        p     = '0;
        c0    = 1'b0;
        grp_g = 1'b0;
        w_c   = '0;
        w_gc  = '0;
        w_gc[0] = i_cin;
        for (int n = 0; n < 8; n++) begin
            g  = w_g[4*n +: 4];
            p  = w_p[4*n +: 4];
            c0 = w_gc[n];
            w_c[4*n]   = c0;
            w_c[4*n+1] = g[0] | (p[0] & c0);
            w_c[4*n+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
            w_c[4*n+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                       | (p[2] & p[1] & p[0] & c0);
            grp_g      = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0]);
            w_gc[n+1]  = grp_g | ((&p) & c0);
        end
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[8];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from the slot after i_ptr and grants the
// first asserted request; grant is one-hot or all-zero when disabled.
module rr_arbiter
    import cla_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_grant_valid
);
    always_comb begin
        logic [ID_W-1:0] v_idx;
        v_idx         = '0;
        o_grant       = '0;
        o_grant_id    = '0;
        o_grant_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_en && !o_grant_valid && i_req[v_idx]) begin
                o_grant[v_idx] = 1'b1;
                o_grant_id     = v_idx;
                o_grant_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cla_adder_arbiter.sv
// Shares one 32-bit CLA adder among NUM_REQ requesters: round-robin grant,
// operand register, result register; fixed two-cycle latency.
module cla_adder_arbiter
    import cla_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ADD_W-1:0] req_a,
    input  logic [NUM_REQ*ADD_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    input  logic                     flush,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [ADD_W-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [31:0]              op_count
);
    logic [ID_W-1:0]  r_ptr;
    logic             r_s1_valid;
    add_op_t          r_s1;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_rsp_valid;
    add_rsp_t         r_rsp;
    logic [31:0]      r_op_count;

    logic [ID_W-1:0]  w_gnt_id;
    logic             w_xfer;
    add_op_t          w_op;
    logic [ADD_W-1:0] w_sum;
    logic             w_cout;
    logic [ADD_W-1:0] w_a_arr [NUM_REQ];
    logic [ADD_W-1:0] w_b_arr [NUM_REQ];
    logic             w_unused_id;

    // No grants while reset is asserted or while the pipe is being flushed.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req         (req_valid),
        .i_ptr         (r_ptr),
        .i_en          (rst_n & ~flush),
        .o_grant       (req_ready),
        .o_grant_id    (w_gnt_id),
        .o_grant_valid (w_xfer)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_a_arr[i] = req_a[i*ADD_W +: ADD_W];
        assign w_b_arr[i] = req_b[i*ADD_W +: ADD_W];
    end

    assign w_op = {w_a_arr[w_gnt_id], w_b_arr[w_gnt_id], req_cin[w_gnt_id]};

    cla32btadder u_add (
        .i_a    (r_s1.a),
        .i_b    (r_s1.b),
        .i_cin  (r_s1.cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= ID_W'(NUM_REQ - 1);
            r_s1_valid  <= 1'b0;
            r_s1        <= '0;
            r_s1_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
            r_op_count  <= '0;
        end else begin
            r_s1_valid  <= w_xfer;
            r_rsp_valid <= r_s1_valid & ~flush;
            if (w_xfer) begin
                r_ptr      <= w_gnt_id;
                r_s1       <= w_op;
                r_s1_id    <= w_gnt_id;
                r_op_count <= r_op_count + 32'd1;
            end
            if (r_s1_valid && !flush) begin
                r_rsp.sum  <= w_sum;
                r_rsp.cout <= w_cout;
                r_rsp.id   <= ID_MAX_W'(r_s1_id);
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp.id[ID_W-1:0];
    assign rsp_sum     = r_rsp.sum;
    assign rsp_cout    = r_rsp.cout;
    assign op_count    = r_op_count;
    assign w_unused_id = ^r_rsp.id;

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Directed bench for cla_adder_arbiter: arbitration order, 2-cycle results,
// flush, asynchronous reset mid-flight and op_count wrap.
module tb_cla_adder_arbiter;
    localparam int N = 4;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_cin;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_sum;
    logic            rsp_cout;
    logic [31:0]     op_count;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    cla_adder_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input logic [3:0] er, input logic erv, input logic [1:0] eid,
                           input logic [31:0] esum, input logic ecout, input logic [31:0] eoc);
        chk($sformatf("s%0d_ready", step_no), 32'(req_ready), 32'(er));
        chk($sformatf("s%0d_rsp_valid", step_no), 32'(rsp_valid), 32'(erv));
        chk($sformatf("s%0d_rsp_id", step_no), 32'(rsp_id), 32'(eid));
        chk($sformatf("s%0d_rsp_sum", step_no), rsp_sum, esum);
        chk($sformatf("s%0d_rsp_cout", step_no), 32'(rsp_cout), 32'(ecout));
        chk($sformatf("s%0d_op_count", step_no), op_count, eoc);
    endtask

    // One clock cycle: drive at edge+1, check at edge+2, advance to next edge+1.
    task automatic cyc(input logic [3:0] v, input logic fl, input logic [3:0] er,
                       input logic erv, input logic [1:0] eid, input logic [31:0] esum,
                       input logic ecout, input logic [31:0] eoc);
        req_valid = v;
        flush     = fl;
        #1;
        chk_out(er, erv, eid, esum, ecout, eoc);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        #1 rst_n  = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'(i);
            req_b[32*i +: 32] = 32'h10;
            req_cin[i]        = 1'b1;
        end
        @(posedge clk);
        #1;
        // In reset with all requests valid: nothing granted, outputs cleared
        cyc(4'hF, 0, 4'b0000, 0, 0, 32'h0, 0, 0);
        cyc(4'hF, 0, 4'b0000, 0, 0, 32'h0, 0, 0);
        rst_n = 1'b1;
        // Round-robin with all four valid: 0,1,2,3,0,1,2,3
        cyc(4'hF, 0, 4'b0001, 0, 0, 32'h00, 0, 0);
        cyc(4'hF, 0, 4'b0010, 0, 0, 32'h00, 0, 1);
        cyc(4'hF, 0, 4'b0100, 1, 0, 32'h11, 0, 2);
        cyc(4'hF, 0, 4'b1000, 1, 1, 32'h12, 0, 3);
        cyc(4'hF, 0, 4'b0001, 1, 2, 32'h13, 0, 4);
        cyc(4'hF, 0, 4'b0010, 1, 3, 32'h14, 0, 5);
        cyc(4'hF, 0, 4'b0100, 1, 0, 32'h11, 0, 6);
        cyc(4'hF, 0, 4'b1000, 1, 1, 32'h12, 0, 7);
        // Sparse after grant to 3: req0 then req2
        cyc(4'b0101, 0, 4'b0001, 1, 2, 32'h13, 0, 8);
        cyc(4'b0100, 0, 4'b0100, 1, 3, 32'h14, 0, 9);
        // req0 and req1 contend with ptr=2: req0 wins; req1 then drops
        cyc(4'b0011, 0, 4'b0001, 1, 0, 32'h11, 0, 10);
        cyc(4'b0000, 0, 4'b0000, 1, 2, 32'h13, 0, 11);
        cyc(4'b0000, 0, 4'b0000, 1, 0, 32'h11, 0, 11);
        cyc(4'b0000, 0, 4'b0000, 0, 0, 32'h11, 0, 11);
        // Single op: 0xFFFFFFFF + 1 + 0 -> sum 0, cout 1
        req_a[31:0] = 32'hFFFF_FFFF;
        req_b[31:0] = 32'h0000_0001;
        req_cin[0]  = 1'b0;
        cyc(4'b0001, 0, 4'b0001, 0, 0, 32'h11, 0, 11);
        cyc(4'b0000, 0, 4'b0000, 0, 0, 32'h11, 0, 12);
        cyc(4'b0000, 0, 4'b0000, 1, 0, 32'h0, 1, 12);
        // Flush in the cycle after accept: response suppressed, count kept
        req_a[127:96] = 32'h1234_5678;
        req_b[127:96] = 32'h1111_1111;
        req_cin[3]    = 1'b1;
        cyc(4'b1000, 0, 4'b1000, 0, 0, 32'h0, 1, 12);
        cyc(4'b1000, 1, 4'b0000, 0, 0, 32'h0, 1, 13);
        cyc(4'b0000, 0, 4'b0000, 0, 0, 32'h0, 1, 13);
        cyc(4'b0000, 0, 4'b0000, 0, 0, 32'h0, 1, 13);
        // Two ops in flight, then asynchronous reset between edges
        cyc(4'b1001, 0, 4'b0001, 0, 0, 32'h0, 1, 13);
        cyc(4'b1000, 0, 4'b1000, 0, 0, 32'h0, 1, 14);
        req_valid = 4'b0000;
        #1;
        chk_out(4'b0000, 1, 0, 32'h0, 1, 15);
        step_no++;
        #2 rst_n = 1'b0;
        #1;
        chk_out(4'b0000, 0, 0, 32'h0, 0, 0);
        step_no++;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(4'b0000, 0, 4'b0000, 0, 0, 32'h0, 0, 0);
        cyc(4'b0000, 0, 4'b0000, 0, 0, 32'h0, 0, 0);
        // op_count wrap: preload to all-ones, then one accepted op
        force dut.r_op_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_op_count;
        cyc(4'b0001, 0, 4'b0001, 0, 0, 32'h0, 0, 32'hFFFF_FFFF);
        cyc(4'b0000, 0, 4'b0000, 0, 0, 32'h0, 0, 0);
        cyc(4'b0000, 0, 4'b0000, 1, 0, 32'h0, 1, 0);
        cyc(4'b0000, 0, 4'b0000, 0, 0, 32'h0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
